// File: rtl/uart_rx_fifo_if.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo_if
// Purpose : bundles the receive-side write port, host-side read port, control
//           inputs and status outputs of the UART receive FIFO.
// Ports   : master modport - driven by the UART receiver / host (writes
//                            strobes and controls, observes status)
//           slave modport  - used by uart_rx_fifo (consumes strobes and
//                            controls, drives head data and status)
// Signals : wr_en, wdata, w_frame_err, w_parity_err  - receive write side
//           rd_en                                     - host pop strobe
//           flush, ovr_clr, rx_trig                   - control
//           rdata, rd_frame_err, rd_parity_err        - show-ahead head entry
//           fifo_full, fifo_empty, count, overrun,
//           rx_trig_irq                               - status
// ----------------------------------------------------------------------------
interface uart_rx_fifo_if #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wdata;
  logic              w_frame_err;
  logic              w_parity_err;
  logic              rd_en;
  logic              flush;
  logic              ovr_clr;
  logic [1:0]        rx_trig;
  logic [DATA_W-1:0] rdata;
  logic              rd_frame_err;
  logic              rd_parity_err;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     count;
  logic              overrun;
  logic              rx_trig_irq;

  modport master (
    output wr_en, wdata, w_frame_err, w_parity_err, rd_en, flush, ovr_clr, rx_trig,
    input  rdata, rd_frame_err, rd_parity_err, fifo_full, fifo_empty, count,
           overrun, rx_trig_irq
  );

  modport slave (
    input  wr_en, wdata, w_frame_err, w_parity_err, rd_en, flush, ovr_clr, rx_trig,
    output rdata, rd_frame_err, rd_parity_err, fifo_full, fifo_empty, count,
           overrun, rx_trig_irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
// Purpose : circular receive FIFO for a UART. Each entry stores the received
//           character together with its frame and parity error flags. The
//           head entry is presented with zero latency (show-ahead). Tracks a
//           sticky overrun flag and a programmable occupancy trigger.
// Ports   : clk - rising-edge clock
//           rst - asynchronous active-high reset
//           bus - uart_rx_fifo_if.slave (write/read strobes, controls, status)
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_W + 2;
  // Trigger levels are compared in a wider domain so the fixed level 8 never
  // aliases when DEPTH is small.
  localparam int LW = CW + 3;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;

  logic          full_s;
  logic          empty_s;
  logic          do_wr_s;
  logic          do_rd_s;
  logic          ovr_evt_s;
  logic [EW-1:0] head_s;
  logic [LW-1:0] trig_level_s;

  assign full_s  = (count_q == CW'(DEPTH));
  assign empty_s = (count_q == {CW{1'b0}});

  // A write is accepted when not full, or when full but a pop frees the slot
  // in the same cycle. Flush overrides both strobes.
  assign do_wr_s   = bus.wr_en & (~full_s | bus.rd_en) & ~bus.flush;
  assign do_rd_s   = bus.rd_en & ~empty_s & ~bus.flush;
  assign ovr_evt_s = bus.wr_en & full_s & ~bus.rd_en & ~bus.flush;

  // Next-state for pointers, occupancy and the sticky overrun flag
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (bus.flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (do_wr_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_rd_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // A new overrun event wins over a coincident clear.
    if (ovr_evt_s) begin
      overrun_d = 1'b1;
    end else if (bus.ovr_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Control state register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      count_q   <= {CW{1'b0}};
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Entry storage; contents are not reset because occupancy governs validity
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_q[wr_ptr_q] <= {bus.w_frame_err, bus.w_parity_err, bus.wdata};
    end
  end

  assign head_s = mem_q[rd_ptr_q];

  // Trigger level decode from rx_trig
  always_comb begin
    trig_level_s = {LW{1'b0}};
    case (bus.rx_trig)
      2'b00:   trig_level_s = LW'(1);
      2'b01:   trig_level_s = LW'(4);
      2'b10:   trig_level_s = LW'(8);
      2'b11:   trig_level_s = LW'(DEPTH - 2);
      default: trig_level_s = LW'(1);
    endcase
  end

  // Head entry is forced to zero when empty so stale storage never leaks out.
  assign bus.rdata         = empty_s ? {DATA_W{1'b0}} : head_s[DATA_W-1:0];
  assign bus.rd_parity_err = empty_s ? 1'b0 : head_s[DATA_W];
  assign bus.rd_frame_err  = empty_s ? 1'b0 : head_s[DATA_W+1];
  assign bus.fifo_full     = full_s;
  assign bus.fifo_empty    = empty_s;
  assign bus.count         = count_q;
  assign bus.overrun       = overrun_q;
  assign bus.rx_trig_irq   = (LW'(count_q) >= trig_level_s);

endmodule
